// File: rtl/sr_drive_ctrl_if.sv
// Purpose : command / feedback / status bundle between a controller and sr_drive_ctrl.
// Latency : n/a (wires only).
// Backpressure: none; requests are only honoured while the controller reports busy=0.
//
// Ports (signals)
//   set_req, clr_req : operation requests (acted on only when idle)
//   fault_clr        : clears the sticky fault flag
//   q_fb, qn_fb      : Q / Q_n read back from the downstream SR latch
//   S, R             : latch drives (never both high)
//   busy, done       : status; done is a one-cycle completion pulse
//   q_exp, fault     : expected latch state and sticky feedback-mismatch flag
interface sr_drive_ctrl_if;
    logic set_req;
    logic clr_req;
    logic fault_clr;
    logic q_fb;
    logic qn_fb;
    logic S;
    logic R;
    logic busy;
    logic done;
    logic q_exp;
    logic fault;

    modport master (
        output set_req, clr_req, fault_clr, q_fb, qn_fb,
        input  S, R, busy, done, q_exp, fault
    );

    modport slave (
        input  set_req, clr_req, fault_clr, q_fb, qn_fb,
        output S, R, busy, done, q_exp, fault
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Purpose : pulse-drives an external SR latch (S or R for PULSE_W cycles, then GAP_W quiet cycles) and checks its feedback.
// Latency : request sampled at edge n -> drive cycles n+1..n+PULSE_W, done pulse at cycle n+PULSE_W+GAP_W+1.
// Backpressure: busy=1 outside IDLE; requests arriving while busy are dropped, not queued.
//
// Ports
//   i_clk  : single clock, all state changes on the rising edge
//   i_rst  : synchronous active-high reset; aborts any pulse and restarts with a clear
//   io_ctl : sr_drive_ctrl_if.slave bundle (requests, latch feedback, drives, status)
module sr_drive_ctrl #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sr_drive_ctrl_if.slave io_ctl
);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_IDLE = 3'd1,
        ST_SET  = 3'd2,
        ST_CLR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_W - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_s;
    logic       r_r;
    logic       r_busy;
    logic       r_done;
    logic       r_q_exp;
    logic       r_fault;
    logic       r_req;      // current pulse came from a request (BOOT clear does not report done)

    // Feedback is bad when Q disagrees with what we last drove, or Q/Q_n are not complementary.
    logic w_fb_bad;
    assign w_fb_bad = (io_ctl.q_fb != r_q_exp) || (io_ctl.q_fb == io_ctl.qn_fb);

    // S/R are registered alongside the state so they are pure functions of it
    // and can never overlap, even across a reset edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_BOOT;
            r_cnt   <= 8'd0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_q_exp <= 1'b0;
            r_fault <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Clear first; a fault detected on this same edge overrides it below.
            if (io_ctl.fault_clr) begin
                r_fault <= 1'b0;
            end

            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_CLR;
                    r_r     <= 1'b1;
                    r_s     <= 1'b0;
                    r_busy  <= 1'b1;
                    r_cnt   <= 8'd0;
                    r_req   <= 1'b0;
                end

                ST_IDLE: begin
                    if (w_fb_bad) begin
                        r_fault <= 1'b1;
                    end
                    // Clear has priority over set when both are requested.
                    if (io_ctl.clr_req) begin
                        r_state <= ST_CLR;
                        r_r     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b1;
                    end else if (io_ctl.set_req) begin
                        r_state <= ST_SET;
                        r_s     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b1;
                    end
                end

                ST_SET, ST_CLR: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state <= ST_GAP;
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_q_exp <= (r_state == ST_SET);
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= r_req;
                        r_req   <= 1'b0;
                        r_cnt   <= 8'd0;
                        // Latch has had GAP_W quiet cycles to settle; check it now.
                        if (w_fb_bad) begin
                            r_fault <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_BOOT;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_busy  <= 1'b1;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    assign io_ctl.S     = r_s;
    assign io_ctl.R     = r_r;
    assign io_ctl.busy  = r_busy;
    assign io_ctl.done  = r_done;
    assign io_ctl.q_exp = r_q_exp;
    assign io_ctl.fault = r_fault;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Purpose : self-checking bench for sr_drive_ctrl with a behavioural SR latch on the feedback path.
// Latency : n/a.
// Backpressure: n/a.
module tb_sr_drive_ctrl;

    localparam int PW = 4;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_drive_ctrl_if ifc ();

    sr_drive_ctrl #(.PULSE_W(PW), .GAP_W(GW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_ctl (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int overlap = 0;

    // Behavioural SR latch, powered up in the "wrong" state so the boot clear matters.
    logic lq        = 1'b1;
    logic force_bad = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.S)      lq <= 1'b1;
        else if (ifc.R) lq <= 1'b0;
    end

    assign ifc.q_fb  = force_bad ? 1'b0 : lq;
    assign ifc.qn_fb = force_bad ? 1'b0 : ~lq;

    always @(negedge clk) begin
        if (ifc.S && ifc.R) overlap++;
    end

    typedef struct {
        logic q;
        logic flt;
        int   done_cyc;
        int   s_cnt;
        int   r_cnt;
    } exp_t;

    exp_t sbq[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request; expectations go on the scoreboard now and are checked when done appears.
    task automatic do_op(input logic set, input logic clr, input logic exp_q, input logic exp_flt,
                         input bit stray, input bit bad, input string name);
        exp_t e;
        int   s_n = 0;
        int   r_n = 0;
        bit   got = 0;
        e.q        = exp_q;
        e.flt      = exp_flt;
        e.done_cyc = cyc + PW + GW + 1;
        e.s_cnt    = (set && !clr) ? PW : 0;
        e.r_cnt    = clr ? PW : 0;
        sbq.push_back(e);
        ifc.set_req = set;
        ifc.clr_req = clr;
        for (int i = 0; i < 40 && !got; i++) begin
            tick;
            ifc.set_req = stray && (i == 1);
            ifc.clr_req = 1'b0;
            s_n += int'(ifc.S);
            r_n += int'(ifc.R);
            if (bad && ifc.S) force_bad = 1'b1;
            if (ifc.done) got = 1;
        end
        force_bad = 1'b0;
        e = sbq.pop_front();
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s: done not seen within 40 cycles", name);
        end else begin
            if (cyc !== e.done_cyc) begin
                n_bad++;
                $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, e.done_cyc);
            end
            n_vec++;
            if ({ifc.q_exp, ifc.fault, lq} !== {e.q, e.flt, e.q}) begin
                n_bad++;
                $display("FAIL %s q_exp/fault/latch: got %b%b%b want %b%b%b",
                         name, ifc.q_exp, ifc.fault, lq, e.q, e.flt, e.q);
            end
            n_vec++;
            if (s_n !== e.s_cnt || r_n !== e.r_cnt) begin
                n_bad++;
                $display("FAIL %s pulse_len: S=%0d R=%0d want S=%0d R=%0d",
                         name, s_n, r_n, e.s_cnt, e.r_cnt);
            end
        end
    endtask

    // Releases reset and follows the BOOT clear cycle by cycle.
    task automatic boot_release(input string name);
        logic [3:0] want;
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick;
            if (i <= 4)      want = 4'b0110;   // {S,R,busy,done}
            else if (i <= 6) want = 4'b0010;
            else             want = 4'b0000;
            n_vec++;
            if ({ifc.S, ifc.R, ifc.busy, ifc.done} !== want) begin
                n_bad++;
                $display("FAIL %s boot_c%0d {S,R,busy,done}: got %b want %b",
                         name, i, {ifc.S, ifc.R, ifc.busy, ifc.done}, want);
            end
        end
        n_vec++;
        if ({ifc.q_exp, ifc.fault, lq} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s boot_end {q_exp,fault,latch}: got %b want 000",
                     name, {ifc.q_exp, ifc.fault, lq});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_vec++;
            if ({ifc.S, ifc.R, ifc.busy, ifc.done, ifc.q_exp, ifc.fault} !== 6'b001000) begin
                n_bad++;
                $display("FAIL reset_hold c%0d: got %b want 001000", i,
                         {ifc.S, ifc.R, ifc.busy, ifc.done, ifc.q_exp, ifc.fault});
            end
        end
        boot_release("reset");
    endtask

    task automatic test_set;
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "set");
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "set_repeat");
    endtask

    task automatic test_both;
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "set_and_clr");
    endtask

    task automatic test_ignore;
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "clr_stray_set");
        for (int i = 0; i < 5; i++) begin
            tick;
            n_vec++;
            if ({ifc.busy, ifc.S} !== 2'b00) begin
                n_bad++;
                $display("FAIL ignore_idle c%0d {busy,S}: got %b want 00", i, {ifc.busy, ifc.S});
            end
        end
    endtask

    task automatic test_fault_gap;
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "set_bad_fb");
        do_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "clr_sticky");
        ifc.fault_clr = 1'b1;
        tick;
        ifc.fault_clr = 1'b0;
        n_vec++;
        if (ifc.fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_clr: got %b want 0", ifc.fault);
        end
    endtask

    task automatic test_fault_idle;
        force_bad     = 1'b1;
        ifc.fault_clr = 1'b1;
        tick;
        n_vec++;
        if (ifc.fault !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_fault_vs_clr: got %b want 1", ifc.fault);
        end
        force_bad = 1'b0;
        tick;
        ifc.fault_clr = 1'b0;
        n_vec++;
        if (ifc.fault !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_fault_release: got %b want 0", ifc.fault);
        end
    endtask

    task automatic test_back_to_back;
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "b2b_set");
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_clr");
    endtask

    task automatic test_reset_mid;
        // Leave a sticky fault behind so reset visibly clears it.
        force_bad = 1'b1;
        tick;
        force_bad = 1'b0;
        ifc.set_req = 1'b1;
        tick;
        ifc.set_req = 1'b0;
        tick;
        n_vec++;
        if ({ifc.S, ifc.fault} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_pre {S,fault}: got %b want 11", {ifc.S, ifc.fault});
        end
        rst = 1'b1;
        tick;
        n_vec++;
        if ({ifc.S, ifc.R, ifc.busy, ifc.done, ifc.q_exp, ifc.fault} !== 6'b001000) begin
            n_bad++;
            $display("FAIL mid_abort: got %b want 001000",
                     {ifc.S, ifc.R, ifc.busy, ifc.done, ifc.q_exp, ifc.fault});
        end
        tick;
        boot_release("reset_mid");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.set_req   = 1'b0;
        ifc.clr_req   = 1'b0;
        ifc.fault_clr = 1'b0;
        test_reset();
        test_set();
        test_both();
        test_ignore();
        test_fault_gap();
        test_fault_idle();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (overlap !== 0) begin
            n_bad++;
            $display("FAIL s_r_overlap: got %0d cycles want 0", overlap);
        end
        n_vec++;
        if (sbq.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter PULSE_W, default 4, number of cycles S or R is held high per operation (legal 1..255).
REQ-002 Parameter GAP_W, default 2, number of cycles S and R are both low after a pulse before the feedback check (legal 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 set_req  input  1  request to set the latch; sampled only in IDLE.
REQ-006 clr_req  input  1  request to clear the latch; sampled only in IDLE.
REQ-007 fault_clr  input  1  clears the sticky fault flag.
REQ-008 q_fb  input  1  Q fed back from the downstream SR latch.
REQ-009 qn_fb  input  1  Q_n fed back from the downstream SR latch.
REQ-010 S  output  1  set drive to the SR latch.
REQ-011 R  output  1  reset drive to the SR latch.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle pulse on completion of a requested operation.
REQ-014 q_exp  output  1  expected latch state.
REQ-015 fault  output  1  sticky feedback-mismatch flag.

Function
REQ-016 FSM states SHALL be BOOT, IDLE, SET, CLR, GAP; S and R SHALL be Moore outputs: S=1 iff state==SET, R=1 iff state==CLR.
REQ-017 S and R SHALL never be high in the same cycle, under any input sequence including reset.
REQ-018 BOOT SHALL transition to CLR unconditionally on the first edge with rst=0, so the latch is driven to a known 0.
REQ-019 IDLE: clr_req=1 -> CLR; else set_req=1 -> SET; else stay; simultaneous set_req and clr_req SHALL resolve to CLR.
REQ-020 SET/CLR SHALL last exactly PULSE_W cycles (8-bit counter), then go to GAP; q_exp SHALL update (1 for SET, 0 for CLR) on the edge leaving SET/CLR.
REQ-021 GAP SHALL last exactly GAP_W cycles, then go to IDLE.
REQ-022 On the edge ending the last GAP cycle, fault SHALL set if q_fb!=q_exp or q_fb==qn_fb.
REQ-023 In IDLE, fault SHALL also set on any edge where q_fb!=q_exp or q_fb==qn_fb.
REQ-024 fault SHALL remain set until fault_clr=1 or rst=1; a set condition and fault_clr on the same edge SHALL leave fault=1.
REQ-025 set_req/clr_req outside IDLE SHALL be ignored (not queued).
REQ-026 A request matching current q_exp SHALL still execute a full pulse.
REQ-027 done SHALL be high for exactly the first IDLE cycle after a GAP entered from a requested SET/CLR; the BOOT-initiated clear SHALL NOT assert done.
REQ-028 Latency: request sampled at edge n -> S/R high cycles n+1..n+PULSE_W, GAP n+PULSE_W+1..n+PULSE_W+GAP_W, done at cycle n+PULSE_W+GAP_W+1.

Reset
REQ-029 While rst=1: state=BOOT, S=0, R=0, busy=1, done=0, q_exp=0, fault=0, counter=0.
REQ-030 rst asserted mid-operation SHALL abort it: S/R low on the next edge, then full BOOT clear sequence after release.

Verification (PULSE_W=4, GAP_W=2, behavioural SR latch model on feedback)
REQ-031 rst=1 for 3 cycles then 0 -> S=R=0 during reset; R=1 cycles 1-4 after release, GAP 5-6, busy=0 from cycle 7, q_exp=0, done never 1.
REQ-032 set_req one cycle in IDLE -> S=1 for 4 cycles, R=0 throughout, done=1 at cycle 7, q_exp=1, fault=0, latch Q=1.
REQ-033 set_req=clr_req=1 in IDLE -> R=1 for 4 cycles, S stays 0, q_exp=0, done at cycle 7.
REQ-034 set_req pulsed during CLR pulse -> ignored; after done, FSM stays IDLE, S never rises.
REQ-035 q_fb=qn_fb=0 forced during SET -> fault=1 at GAP end; stays 1 through a later clear; drops after fault_clr=1 once feedback valid.
REQ-036 rst=1 at second SET cycle -> S=0 next edge, fault=0, q_exp=0; after release R pulses 4 cycles per REQ-031; S=R=1 never observed.
